// File: rtl/loader_pkg.sv
// Shared definitions for the byte-stream memory loader: FSM state encoding and the default frame marker.
package loader_pkg;

  typedef enum logic [3:0] {
    S_SYNC   = 4'd0,
    S_ADDR_H = 4'd1,
    S_ADDR_L = 4'd2,
    S_LEN_H  = 4'd3,
    S_LEN_L  = 4'd4,
    S_DATA_H = 4'd5,
    S_DATA_L = 4'd6,
    S_CSUM   = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/mem_loader_if.sv
// Host byte link plus dsram write port of the memory loader, bundled with host (master) and loader (slave) views.
interface mem_loader_if #(
  parameter int WIDTH = 13
);

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             we;
  logic [WIDTH-1:0] mem_din_addr;
  logic [15:0]      mem_din;

  modport master (
    output in_valid, in_data,
    input  in_ready, we, mem_din_addr, mem_din
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, we, mem_din_addr, mem_din
  );

endinterface

// File: rtl/mem_loader.sv
// Frame parser that turns a host byte stream into 16-bit dsram writes.
// Optional trailing XOR checksum enabled by defining MEM_LOADER_CHECKSUM_EN.
module mem_loader
  import loader_pkg::*;
#(
  parameter int         WIDTH     = 13,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_loader_if.slave  bus,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam logic [WIDTH-1:0] ADDR_ONE = WIDTH'(1);

`ifdef MEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t           state;
  logic [7:0]       addr_h;
  logic [7:0]       len_h;
  logic [7:0]       hi;
  logic [WIDTH-1:0] addr;
  logic [15:0]      cnt;
  logic             xfer;

  assign xfer         = bus.in_valid & bus.in_ready;
  assign bus.in_ready = (state != S_DONE);
  assign busy         = (state != S_SYNC);
  assign done         = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_SYNC;
      addr_h           <= 8'd0;
      len_h            <= 8'd0;
      hi               <= 8'd0;
      addr             <= '0;
      cnt              <= 16'd0;
      bus.we           <= 1'b0;
      bus.mem_din_addr <= '0;
      bus.mem_din      <= 16'd0;
    end else begin
      bus.we <= 1'b0;
      case (state)
        S_SYNC: begin
          if (xfer && (bus.in_data == SYNC_BYTE)) state <= S_ADDR_H;
        end
        S_ADDR_H: begin
          if (xfer) begin
            addr_h <= bus.in_data;
            state  <= S_ADDR_L;
          end
        end
        S_ADDR_L: begin
          // header address bits above WIDTH are dropped here
          if (xfer) begin
            addr  <= WIDTH'({addr_h, bus.in_data});
            state <= S_LEN_H;
          end
        end
        S_LEN_H: begin
          if (xfer) begin
            len_h <= bus.in_data;
            state <= S_LEN_L;
          end
        end
        S_LEN_L: begin
          if (xfer) begin
            cnt   <= {len_h, bus.in_data};
            state <= ({len_h, bus.in_data} == 16'd0) ? S_TAIL : S_DATA_H;
          end
        end
        S_DATA_H: begin
          if (xfer) begin
            hi    <= bus.in_data;
            state <= S_DATA_L;
          end
        end
        S_DATA_L: begin
          // write issues the cycle after the low byte; cnt==1 marks the final word
          if (xfer) begin
            bus.we           <= 1'b1;
            bus.mem_din_addr <= addr;
            bus.mem_din      <= {hi, bus.in_data};
            addr             <= addr + ADDR_ONE;
            cnt              <= cnt - 16'd1;
            state            <= (cnt == 16'd1) ? S_TAIL : S_DATA_H;
          end
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) state <= S_DONE;
        end
`endif
        S_DONE:  state <= S_SYNC;
        default: state <= S_SYNC;
      endcase
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // running XOR covers ADDR_H through the last DATA_L; the verdict lands with S_DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum  <= 8'd0;
      error <= 1'b0;
    end else if (xfer) begin
      case (state)
        S_SYNC: begin
          if (bus.in_data == SYNC_BYTE) begin
            csum  <= 8'd0;
            error <= 1'b0;
          end
        end
        S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L: begin
          csum <= csum ^ bus.in_data;
        end
        S_CSUM:  error <= (csum != bus.in_data);
        default: ;
      endcase
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Randomized self-checking bench for mem_loader against a frame-level write model.
module tb_mem_loader;

  localparam int WIDTH = 13;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [15:0]      d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, error;

  mem_loader_if #(.WIDTH(WIDTH)) bus ();

  mem_loader #(.WIDTH(WIDTH), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  bit          mon_en   = 1'b0;
  bit          prev_done = 1'b0;
  bit          gap_en   = 1'b0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [15:0] wbuf[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // every write is matched in order against the model's expected list
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", 32'(bus.mem_din_addr), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(bus.mem_din_addr), 32'(mon_e.a));
          check("wr_data", 32'(bus.mem_din), 32'(mon_e.d));
        end
      end
      check("ready_vs_done", 32'(bus.in_ready), 32'(!done));
      if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
      if (done) done_cnt++;
      prev_done = done;
    end
  end

  task automatic check_reset_outputs();
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_addr", 32'(bus.mem_din_addr), 32'd0);
    check("rst_din", 32'(bus.mem_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // called at a negedge; returns at the negedge after the byte was accepted
  task automatic send_byte(input logic [7:0] b);
    int g;
    if (gap_en) begin
      repeat ($urandom_range(0, 3)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    g = 0;
    while (!bus.in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic set_rand_words(input int n);
    wbuf.delete();
    for (int i = 0; i < n; i++) wbuf.push_back(16'($urandom));
  endtask

  // sends a frame carrying wbuf; stop_after >= 0 truncates it after that many bytes
  task automatic send_frame(input logic [15:0] a, input bit bad, input int stop_after);
    logic [7:0]       q[$];
    logic [7:0]       cs;
    int               len, n_send, d0;
    bit               exp_err;
    wr_t              e;
    len = wbuf.size();
    q.push_back(8'hA5);
    q.push_back(a[15:8]);
    q.push_back(a[7:0]);
    q.push_back(8'(len >> 8));
    q.push_back(8'(len));
    foreach (wbuf[i]) begin
      q.push_back(wbuf[i][15:8]);
      q.push_back(wbuf[i][7:0]);
    end
    cs = 8'd0;
    for (int k = 1; k < q.size(); k++) cs = cs ^ q[k];
    exp_err = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
    q.push_back(cs ^ {7'd0, bad});
    exp_err = bad;
`endif
    n_send = (stop_after < 0) ? q.size() : stop_after;
    for (int i = 0; i < len; i++) begin
      if (6 + 2 * i < n_send) begin
        e.a = a[WIDTH-1:0] + WIDTH'(i);
        e.d = wbuf[i];
        exp_q.push_back(e);
      end
    end
    d0 = done_cnt;
    for (int k = 0; k < n_send; k++) begin
      send_byte(q[k]);
      if (k == 0) check("busy_after_sync", 32'(busy), 32'd1);
      if (k >= 6 && k < 5 + 2 * len && ((k - 5) % 2) == 1) check("we_latency", 32'(bus.we), 32'd1);
    end
    if (stop_after < 0) begin
      check("done_latency", 32'(done), 32'd1);
      check("error_at_done", 32'(error), 32'(exp_err));
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("done_once", 32'(done_cnt - d0), 32'd1);
      check("writes_drained", 32'(exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // two-word frame
    wbuf.delete();
    wbuf.push_back(16'h1234);
    wbuf.push_back(16'hABCD);
    send_frame(16'h0010, 1'b0, -1);

    // garbage before sync is dropped silently
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("garbage_busy", 32'(busy), 32'd0);
    check("garbage_error", 32'(error), 32'd0);
    set_rand_words(1);
    send_frame(16'h0123, 1'b0, -1);

    // address wrap and dropped header bits
    set_rand_words(2);
    send_frame(16'h1FFF, 1'b0, -1);
    set_rand_words(3);
    send_frame(16'hFFFE, 1'b0, -1);

    // empty frame
    wbuf.delete();
    send_frame(16'h0020, 1'b0, -1);

`ifdef MEM_LOADER_CHECKSUM_EN
    set_rand_words(1);
    send_frame(16'h0040, 1'b0, -1);
    send_frame(16'h0040, 1'b1, -1);
    repeat (3) @(negedge clk);
    check("error_sticky", 32'(error), 32'd1);
    send_byte(8'h3C);
    check("error_sticky_garbage", 32'(error), 32'd1);
    send_byte(8'hA5);
    check("error_cleared_by_sync", 32'(error), 32'd0);
    set_rand_words(1);
    send_frame(16'h0050, 1'b0, 4);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
`endif

    // abort after the high byte of word 2
    set_rand_words(2);
    send_frame(16'h0300, 1'b0, 8);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_write", 32'(exp_q.size()), 32'd0);
    set_rand_words(2);
    send_frame(16'h0300, 1'b0, -1);

    // random frames with a throttled link
    gap_en = 1'b1;
    for (int f = 0; f < 16; f++) begin
      logic [7:0] g;
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g);
      end
      set_rand_words($urandom_range(0, 4));
      send_frame(16'($urandom), 1'($urandom), -1);
    end
    gap_en = 1'b0;

    repeat (4) @(negedge clk);
    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
